nibble_fetch_unit: RTL and testbench
====================================

# nibble_fetch_unit

Parametrised instruction fetch front-end for the tiny nibble-serial CPU. It drives an instruction address and phase index to external program memory, and assembles `NIBS` nibbles into one instruction word. It presents that word, tagged with its address, on a valid/ready interface to the decode stage. It extends the fixed 3-phase, 10-bit fetcher with configurable widths, consumer back-pressure and PC redirect (jump).

## Interface
- `ADDR_W`, 10, program-counter / memory address width (≥2)
- `NIB_W`, 4, width of one memory nibble (≥1)
- `NIBS`, 3, nibbles per instruction (≥1); `PH_W` = max(1, clog2(NIBS)) derived
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mem_addr`  out  ADDR_W  address of instruction being fetched
- `mem_phase`  out  PH_W  index of nibble requested this cycle (0..NIBS-1)
- `mem_data`  in  NIB_W  nibble returned by memory, combinationally, same cycle
- `instr_valid`  out  1  assembled instruction available
- `instr_ready`  in  1  decode accepts instruction
- `instr_data`  out  NIBS*NIB_W  instruction; nibble 0 in LSBs
- `instr_pc`  out  ADDR_W  address the instruction was fetched from
- `jump_valid`  in  1  redirect PC this cycle
- `jump_addr`  in  ADDR_W  redirect target

## Operation
- State machine:
  - FETCH: phase advances 0→NIBS-1. Each edge stores `mem_data` into slot `mem_phase` of the assembly register.
  - STALL: entered when the last phase is reached but the output buffer cannot take the instruction.
- Last phase completes only if `!instr_valid || instr_ready`. On completion:
  - Output buffer loads the assembled word with `mem_data` as the top nibble.
  - `instr_pc` ← `mem_addr`, `instr_valid` ← 1.
  - `mem_addr` ← `mem_addr`+1, phase ← 0, state FETCH.
- Otherwise go to or remain in STALL. `mem_addr` and `mem_phase` are held at NIBS-1, and the last nibble is resampled every cycle.
- Handshake: a transfer occurs on an edge with `instr_valid && instr_ready`. `instr_valid` drops after the transfer unless a new instruction completes on the same edge. `instr_data` and `instr_pc` are stable while `instr_valid && !instr_ready`.
- Jump (priority over everything except `rst`):
  - `mem_addr` ← `jump_addr`, phase ← 0, state FETCH.
  - Partial assembly is discarded and `instr_valid` ← 0.
  - A simultaneous valid&ready counts as a transfer, but the buffer is still cleared.
- PC arithmetic is modulo 2^ADDR_W: 2^ADDR_W-1 increments to 0.
- NIBS=1: every cycle is a last phase; `mem_phase` is constant 0.

## Timing
- Reset values: `mem_addr`=0, `mem_phase`=0, `instr_valid`=0, `instr_data`=0, `instr_pc`=0, state FETCH, assembly register 0.
- `rst` asserted mid-fetch or mid-stall returns all of the above to reset values on the next edge. Pending instruction and jump are lost.
- First instruction: `instr_valid` rises after the NIBS-th edge following `rst` deassertion.
- Throughput with `instr_ready` held high: one instruction per NIBS cycles, no bubbles.
- Jump on edge t: `mem_addr`=`jump_addr`, `mem_phase`=0 from t. The first redirected instruction is valid after edge t+NIBS.
- No combinational path from `instr_ready` or `jump_*` to any output; all outputs are registered.

## Configuration
- `FETCH_JUMP_EN` defined: jump logic as described.
- Not defined: `jump_valid` and `jump_addr` ports remain but are ignored (listed as unused), PC only increments, and no flush logic is synthesised.

## Structure
- Shared package `fetch_pkg`:
  - state enum (FETCH, STALL)
  - `ph_w(nibs)` width function
  - default parameter constants
- One sub-module: `fetch_out_reg`, the one-entry output buffer. It owns `instr_valid`, `instr_data` and `instr_pc`, and takes load, flush and ready inputs.
- FSM, phase counter, PC and assembly register live in the top module.

## Test plan
- Defaults, `instr_ready`=1, memory returns nibble = (addr+phase)&0xF:
  - first `instr_valid` after the 3rd edge with `instr_data`=0x210, `instr_pc`=0.
  - next instruction after 3 more edges: 0x321, `instr_pc`=1.
- Back-pressure: `instr_ready`=0 for 5 cycles after the first valid.
  - `instr_data` holds 0x210, and `mem_addr`=1 and `mem_phase`=2 are held.
  - After `instr_ready`=1, the instruction from addr 1 transfers with no loss or duplication.
- Wrap: jump to 0x3FF.
  - Instruction reports `instr_pc`=0x3FF, then `mem_addr`=0x000.
- Jump mid-fetch: `jump_valid`=1, `jump_addr`=0x155 while at phase 1 of addr 4.
  - `mem_addr`=0x155 and phase 0 next cycle, `instr_valid`=0.
  - Next instruction reports `instr_pc`=0x155.
- Reset mid-stall: `rst`=1 for one cycle while in STALL with `instr_valid`=1.
  - All outputs zero the next cycle; first valid again after 3 edges.
- NIBS=1, NIB_W=8:
  - One instruction per cycle, `instr_data`=`mem_data`, `mem_phase` constant 0.
  - Repeat with `FETCH_JUMP_EN` undefined: `jump_valid` has no effect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the nibble-serial instruction fetch front-end.
//   - fetch_state_e : fetch FSM states
//   - ph_w()        : phase-index width for a given nibbles-per-instruction count
//   - Def*          : default parameter values (10-bit PC, 4-bit nibble, 3 nibbles)
package fetch_pkg;

  typedef enum logic [0:0] {
    StFetch,
    StStall
  } fetch_state_e;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefNibW  = 4;
  localparam int unsigned DefNibs  = 3;

  // A phase index never narrower than one bit, even when NIBS is 1.
  function automatic int unsigned ph_w(input int unsigned nibs);
    return (nibs <= 1) ? 1 : $clog2(nibs);
  endfunction

endpackage

// File: rtl/nibble_fetch_unit_if.sv
// Bus bundle of the fetch unit: program-memory request/response and the
// instruction valid/ready output, plus the PC redirect inputs.
//   master : the fetch unit (drives mem_addr/mem_phase and instr_*)
//   slave  : memory + decode side (drives mem_data, instr_ready, jump_*)
interface nibble_fetch_unit_if #(
  parameter int unsigned ADDR_W = fetch_pkg::DefAddrW,
  parameter int unsigned NIB_W  = fetch_pkg::DefNibW,
  parameter int unsigned NIBS   = fetch_pkg::DefNibs
);

  localparam int unsigned PH_W    = fetch_pkg::ph_w(NIBS);
  localparam int unsigned INSTR_W = NIBS * NIB_W;

  logic [ADDR_W-1:0]  mem_addr;
  logic [PH_W-1:0]    mem_phase;
  logic [NIB_W-1:0]   mem_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;
  logic               jump_valid;
  logic [ADDR_W-1:0]  jump_addr;

  modport master (
    output mem_addr,
    output mem_phase,
    input  mem_data,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_pc,
    input  jump_valid,
    input  jump_addr
  );

  modport slave (
    input  mem_addr,
    input  mem_phase,
    output mem_data,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_pc,
    output jump_valid,
    output jump_addr
  );

endinterface

// File: rtl/fetch_out_reg.sv
// One-entry output buffer holding the assembled instruction for decode.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   load_i            : a new instruction completes this cycle
//   flush_i           : drop any held instruction (PC redirect)
//   ready_i           : decode accepts the held instruction
//   data_i, pc_i      : instruction word and its fetch address to load
//   valid_o, data_o, pc_o : registered buffer contents
// Priority: reset > flush > load > transfer-only.
module fetch_out_reg #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      // Load is only requested when the slot is empty or draining this edge.
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/nibble_fetch_unit.sv
// Instruction fetch front-end for the nibble-serial CPU. Walks the phase index
// 0..NIBS-1 for the current PC, collects one nibble per cycle from program
// memory, and hands the finished word (tagged with its PC) to decode through a
// one-entry valid/ready buffer. Stalls on the last phase while the buffer is full.
//   clk, rst : clock, synchronous active-high reset
//   bus      : nibble_fetch_unit_if.master (mem_addr/mem_phase out, mem_data in,
//              instr_valid/instr_data/instr_pc out, instr_ready in, jump_* in)
// Build option: define FETCH_JUMP_EN to enable PC redirect via jump_valid/jump_addr;
// otherwise those inputs are ignored and the PC only increments.
module nibble_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NIB_W  = DefNibW,
  parameter int unsigned NIBS   = DefNibs
) (
  input  logic                clk,
  input  logic                rst,
  nibble_fetch_unit_if.master bus
);

  localparam int unsigned     PH_W    = ph_w(NIBS);
  localparam int unsigned     INSTR_W = NIBS * NIB_W;
  localparam logic [PH_W-1:0] LastPh  = PH_W'(NIBS - 1);

  fetch_state_e       state_q;
  logic [PH_W-1:0]    phase_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] asm_q;
  logic [INSTR_W-1:0] asm_d;

  logic               out_valid;
  logic [INSTR_W-1:0] out_data;
  logic [ADDR_W-1:0]  out_pc;

  logic               at_last;
  logic               can_load;
  logic               complete;
  logic               flush;

`ifdef FETCH_JUMP_EN
  assign flush = bus.jump_valid;
`else
  assign flush = 1'b0;
  logic unused_jump;
  assign unused_jump = ^{bus.jump_valid, bus.jump_addr};
`endif

  assign at_last  = (state_q == StStall) || (phase_q == LastPh);
  // The buffer can take a word if it is empty or its contents leave this edge.
  assign can_load = !out_valid || bus.instr_ready;
  assign complete = at_last && can_load && !flush;

  // Current nibble lands in its slot; on the last phase asm_d is the full word.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < NIBS; i++) begin
      if (phase_q == PH_W'(i)) begin
        asm_d[i*NIB_W +: NIB_W] = bus.mem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      phase_q <= '0;
      addr_q  <= '0;
      asm_q   <= '0;
    end else if (flush) begin
`ifdef FETCH_JUMP_EN
      state_q <= StFetch;
      phase_q <= '0;
      addr_q  <= bus.jump_addr;
      asm_q   <= '0;
`endif
    end else begin
      asm_q <= asm_d;
      if (at_last) begin
        if (can_load) begin
          state_q <= StFetch;
          phase_q <= '0;
          addr_q  <= addr_q + ADDR_W'(1);
        end else begin
          // Hold address and phase; the last nibble is resampled each cycle.
          state_q <= StStall;
        end
      end else begin
        phase_q <= phase_q + PH_W'(1);
      end
    end
  end

  fetch_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_out_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (complete),
    .flush_i (flush),
    .ready_i (bus.instr_ready),
    .data_i  (asm_d),
    .pc_i    (addr_q),
    .valid_o (out_valid),
    .data_o  (out_data),
    .pc_o    (out_pc)
  );

  assign bus.mem_addr    = addr_q;
  assign bus.mem_phase   = phase_q;
  assign bus.instr_valid = out_valid;
  assign bus.instr_data  = out_data;
  assign bus.instr_pc    = out_pc;

endmodule

// File: tb/tb_nibble_fetch_unit.sv
// Bench for nibble_fetch_unit: a default 3x4-bit instance and a 1x8-bit instance.
// Memory returns (addr+phase) truncated to the nibble width. Expected words are
// queued per instruction and checked as each one transfers to decode.
`timescale 1ns/1ps
module tb_nibble_fetch_unit;

`ifdef FETCH_JUMP_EN
  localparam bit JumpEn = 1'b1;
`else
  localparam bit JumpEn = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  pc;
    logic [11:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3;
  logic rst1;

  nibble_fetch_unit_if #(.ADDR_W(10), .NIB_W(4), .NIBS(3)) bus3 ();
  nibble_fetch_unit_if #(.ADDR_W(10), .NIB_W(8), .NIBS(1)) bus1 ();

  nibble_fetch_unit #(.ADDR_W(10), .NIB_W(4), .NIBS(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  nibble_fetch_unit #(.ADDR_W(10), .NIB_W(8), .NIBS(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  // Program memory models.
  logic [9:0] sum3;
  assign sum3          = bus3.mem_addr + 10'(bus3.mem_phase);
  assign bus3.mem_data = sum3[3:0];
  assign bus1.mem_data = bus1.mem_addr[7:0] + 8'(bus1.mem_phase);

  exp_t       sb3[$];
  exp_t       sb1[$];
  logic [9:0] exp_pc3;
  logic [9:0] exp_pc1;
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic logic [11:0] word3(input logic [9:0] a);
    logic [9:0] a1;
    logic [9:0] a2;
    a1 = a + 10'd1;
    a2 = a + 10'd2;
    return {a2[3:0], a1[3:0], a[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_n3(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = exp_pc3;
      e.data = word3(exp_pc3);
      sb3.push_back(e);
      exp_pc3 = exp_pc3 + 10'd1;
    end
  endtask

  task automatic push_n1(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = exp_pc1;
      e.data = {4'h0, exp_pc1[7:0]};
      sb1.push_back(e);
      exp_pc1 = exp_pc1 + 10'd1;
    end
  endtask

  // One clock: score any transfer happening at this edge, then step past it.
  task automatic tick();
    exp_t e;
    if (!rst3 && bus3.instr_valid && bus3.instr_ready) begin
      if (sb3.size() == 0) begin
        check("sb3_unexpected_instr", 32'(sb3.size()), 32'd1);
      end else begin
        e = sb3.pop_front();
        check("sb3_data", 32'(bus3.instr_data), 32'(e.data));
        check("sb3_pc", 32'(bus3.instr_pc), 32'(e.pc));
      end
    end
    if (!rst1 && bus1.instr_valid && bus1.instr_ready) begin
      if (sb1.size() == 0) begin
        check("sb1_unexpected_instr", 32'(sb1.size()), 32'd1);
      end else begin
        e = sb1.pop_front();
        check("sb1_data", 32'(bus1.instr_data), 32'(e.data));
        check("sb1_pc", 32'(bus1.instr_pc), 32'(e.pc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max, output int used);
    used = 0;
    while ((sb3.size() != 0 || sb1.size() != 0) && used < max) begin
      tick();
      used++;
    end
    check("drain_left", 32'(sb3.size() + sb1.size()), 32'd0);
  endtask

  task automatic wait_valid3(input int max, output int used);
    used = 0;
    while (!bus3.instr_valid && used < max) begin
      tick();
      used++;
    end
    check("wait_valid3", 32'(bus3.instr_valid), 32'd1);
  endtask

  task automatic reset3(input logic ready);
    rst3 = 1'b1;
    bus3.instr_ready = ready;
    tick();
    sb3.delete();
    exp_pc3 = '0;
    rst3 = 1'b0;
  endtask

  initial begin
    int         t;
    logic [9:0] jt;

    rst3 = 1'b1;
    rst1 = 1'b1;
    bus3.instr_ready = 1'b1;
    bus3.jump_valid  = 1'b0;
    bus3.jump_addr   = '0;
    bus1.instr_ready = 1'b1;
    bus1.jump_valid  = 1'b0;
    bus1.jump_addr   = '0;
    exp_pc3 = '0;
    exp_pc1 = '0;
    tick();
    tick();
    check("rst_addr", 32'(bus3.mem_addr), 32'd0);
    check("rst_phase", 32'(bus3.mem_phase), 32'd0);
    check("rst_valid", 32'(bus3.instr_valid), 32'd0);
    check("rst_data", 32'(bus3.instr_data), 32'd0);
    check("rst_pc", 32'(bus3.instr_pc), 32'd0);

    // First two instructions with decode always ready.
    rst3 = 1'b0;
    push_n3(2);
    tick();
    tick();
    check("first_not_early", 32'(bus3.instr_valid), 32'd0);
    tick();
    check("first_valid", 32'(bus3.instr_valid), 32'd1);
    check("first_data", 32'(bus3.instr_data), 32'h210);
    check("first_pc", 32'(bus3.instr_pc), 32'd0);
    repeat (3) tick();
    check("second_valid", 32'(bus3.instr_valid), 32'd1);
    check("second_data", 32'(bus3.instr_data), 32'h321);
    check("second_pc", 32'(bus3.instr_pc), 32'd1);
    drain(4, t);
    // Four more back-to-back: one every 3 cycles, no bubbles.
    push_n3(4);
    drain(20, t);
    check("throughput_cycles", 32'(t), 32'd12);

    // Back-pressure: decode stalls for 5 cycles after the first valid.
    reset3(1'b0);
    push_n3(3);
    repeat (3) tick();
    check("bp_valid", 32'(bus3.instr_valid), 32'd1);
    check("bp_data", 32'(bus3.instr_data), 32'h210);
    repeat (5) tick();
    check("bp_hold_valid", 32'(bus3.instr_valid), 32'd1);
    check("bp_hold_data", 32'(bus3.instr_data), 32'h210);
    check("bp_hold_pc", 32'(bus3.instr_pc), 32'd0);
    check("bp_hold_addr", 32'(bus3.mem_addr), 32'd1);
    check("bp_hold_phase", 32'(bus3.mem_phase), 32'd2);
    bus3.instr_ready = 1'b1;
    tick();
    check("bp_next_valid", 32'(bus3.instr_valid), 32'd1);
    check("bp_next_data", 32'(bus3.instr_data), 32'h321);
    check("bp_next_pc", 32'(bus3.instr_pc), 32'd1);
    drain(10, t);

    // Jump while at phase 1 of address 4.
    reset3(1'b1);
    push_n3(4);
    repeat (13) tick();
    check("jm_pre_addr", 32'(bus3.mem_addr), 32'd4);
    check("jm_pre_phase", 32'(bus3.mem_phase), 32'd1);
    check("jm_pre_valid", 32'(bus3.instr_valid), 32'd0);
    bus3.jump_valid = 1'b1;
    bus3.jump_addr  = 10'h155;
    tick();
    bus3.jump_valid = 1'b0;
    jt = JumpEn ? 10'h155 : 10'd4;
    check("jm_addr", 32'(bus3.mem_addr), 32'(jt));
    check("jm_phase", 32'(bus3.mem_phase), JumpEn ? 32'd0 : 32'd2);
    check("jm_valid", 32'(bus3.instr_valid), 32'd0);
    exp_pc3 = jt;
    push_n3(1);
    wait_valid3(8, t);
    check("jm_first_pc", 32'(bus3.instr_pc), 32'(jt));
    check("jm_latency", 32'(t), JumpEn ? 32'd3 : 32'd1);
    drain(4, t);

    // PC wrap: run through the whole address space.
    reset3(1'b1);
    push_n3(1023);
    drain(3 * 1023 + 8, t);
    push_n3(1);
    wait_valid3(6, t);
    check("wrap_pc", 32'(bus3.instr_pc), 32'h3FF);
    check("wrap_data", 32'(bus3.instr_data), 32'h10F);
    check("wrap_addr", 32'(bus3.mem_addr), 32'd0);
    drain(4, t);

    // Reset while stalled with an instruction pending.
    reset3(1'b0);
    repeat (7) tick();
    check("rs_pre_valid", 32'(bus3.instr_valid), 32'd1);
    check("rs_pre_addr", 32'(bus3.mem_addr), 32'd1);
    check("rs_pre_phase", 32'(bus3.mem_phase), 32'd2);
    rst3 = 1'b1;
    tick();
    check("rs_addr", 32'(bus3.mem_addr), 32'd0);
    check("rs_phase", 32'(bus3.mem_phase), 32'd0);
    check("rs_valid", 32'(bus3.instr_valid), 32'd0);
    check("rs_data", 32'(bus3.instr_data), 32'd0);
    check("rs_pc", 32'(bus3.instr_pc), 32'd0);
    rst3 = 1'b0;
    bus3.instr_ready = 1'b1;
    push_n3(1);
    tick();
    tick();
    check("rs_not_early", 32'(bus3.instr_valid), 32'd0);
    tick();
    check("rs_first_valid", 32'(bus3.instr_valid), 32'd1);
    check("rs_first_data", 32'(bus3.instr_data), 32'h210);
    drain(4, t);

    // NIBS=1, NIB_W=8: one instruction per cycle.
    rst3 = 1'b1;
    rst1 = 1'b0;
    push_n1(8);
    tick();
    check("n1_first_valid", 32'(bus1.instr_valid), 32'd1);
    check("n1_first_data", 32'(bus1.instr_data), 32'd0);
    check("n1_first_pc", 32'(bus1.instr_pc), 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("n1_phase", 32'(bus1.mem_phase), 32'd0);
      check("n1_valid", 32'(bus1.instr_valid), 32'd1);
    end
    drain(3, t);
    // Jump coinciding with a transfer: the transfer counts, the buffer clears.
    push_n1(1);
    bus1.jump_valid = 1'b1;
    bus1.jump_addr  = 10'h02A;
    tick();
    bus1.jump_valid = 1'b0;
    check("n1_jaddr", 32'(bus1.mem_addr), JumpEn ? 32'h02A : 32'd10);
    check("n1_jvalid", 32'(bus1.instr_valid), JumpEn ? 32'd0 : 32'd1);
    check("n1_jphase", 32'(bus1.mem_phase), 32'd0);
    exp_pc1 = JumpEn ? 10'h02A : exp_pc1;
    push_n1(3);
    drain(6, t);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
